// File: rtl/button_debouncer.sv
// Push-button conditioner: per-channel synchroniser plus run-length debounce,
// producing a registered stable level and a one-cycle change event.
module button_debouncer #(
  parameter int   N_BUTTONS       = 2,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 120000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic                 clk,
  input  logic                 sresetn,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] button_events
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic                   level_q;
    logic                   event_q;
    logic [CNT_W-1:0]       cnt_q;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Level and event move on the same edge so that event && level reads as
    // a release downstream; any matching cycle restarts the debounce run.
    always_ff @(posedge clk) begin
      if (!sresetn) begin
        sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
        level_q <= RESET_LEVEL;
        event_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], buttons_raw[i]};
        event_q <= 1'b0;
        if (sync_bit == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          level_q <= sync_bit;
          event_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign buttons[i]       = level_q;
    assign button_events[i] = event_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: scripted vector table, a hand-timed latency
// check, then randomized bouncing inputs compared against a behavioural model.
module tb_button_debouncer;

  localparam int N   = 2;
  localparam int SYN = 2;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         sresetn;
  logic [N-1:0] buttons_raw;
  logic [N-1:0] buttons;
  logic [N-1:0] button_events;

  int total = 0;
  int bad   = 0;

  button_debouncer #(
    .N_BUTTONS      (N),
    .SYNC_STAGES    (SYN),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_LEVEL    (1'b1)
  ) dut (
    .clk          (clk),
    .sresetn      (sresetn),
    .buttons_raw  (buttons_raw),
    .buttons      (buttons),
    .button_events(button_events)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples delayed SYN edges, then count consecutive
  // disagreeing samples; DEB in a row flips the level and flags an event.
  logic [N-1:0] hist[$];
  int           run[N];
  logic [N-1:0] m_level;
  logic [N-1:0] m_event;

  task automatic model_edge(input logic rstn_v, input logic [N-1:0] raw_v);
    logic [N-1:0] s;
    if (!rstn_v) begin
      hist.delete();
      for (int k = 0; k < SYN; k++) hist.push_back('1);
      m_level = '1;
      m_event = '0;
      for (int c = 0; c < N; c++) run[c] = 0;
    end else begin
      s = hist[SYN-1];
      hist.push_front(raw_v);
      void'(hist.pop_back());
      m_event = '0;
      for (int c = 0; c < N; c++) begin
        if (s[c] != m_level[c]) begin
          run[c]++;
          if (run[c] == DEB) begin
            m_level[c] = s[c];
            m_event[c] = 1'b1;
            run[c]     = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  endtask

  task automatic tick(input logic rstn_v, input logic [N-1:0] raw_v);
    sresetn     = rstn_v;
    buttons_raw = raw_v;
    @(posedge clk);
    model_edge(rstn_v, raw_v);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic         rstn;
    logic [N-1:0] raw;
    int           n;
    logic [N-1:0] eb;
    logic [N-1:0] ee;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rstn, logic [N-1:0] raw, int n,
                              logic [N-1:0] eb, logic [N-1:0] ee);
    vec_t v;
    v.rstn = rstn; v.raw = raw; v.n = n; v.eb = eb; v.ee = ee;
    tbl.push_back(v);
  endfunction

  initial begin
    int           cyc;
    int           hold[N];
    logic [N-1:0] rraw;
    logic         rrst;

    sresetn     = 1'b0;
    buttons_raw = '1;
    #2;

    // reset held, then idle
    add(0, 2'b11,  3, 2'b11, 2'b00);
    add(1, 2'b11, 20, 2'b11, 2'b00);
    // clean press / release on bit 0
    add(1, 2'b10,  5, 2'b11, 2'b00);
    add(1, 2'b10,  1, 2'b10, 2'b01);
    add(1, 2'b10, 10, 2'b10, 2'b00);
    add(1, 2'b11,  5, 2'b10, 2'b00);
    add(1, 2'b11,  1, 2'b11, 2'b01);
    add(1, 2'b11, 10, 2'b11, 2'b00);
    // short glitch on bit 1
    add(1, 2'b01,  3, 2'b11, 2'b00);
    add(1, 2'b11, 10, 2'b11, 2'b00);
    // bounce on bit 0, then a stable press
    add(1, 2'b10,  3, 2'b11, 2'b00);
    add(1, 2'b11,  3, 2'b11, 2'b00);
    add(1, 2'b10,  3, 2'b11, 2'b00);
    add(1, 2'b11,  3, 2'b11, 2'b00);
    add(1, 2'b10,  5, 2'b11, 2'b00);
    add(1, 2'b10,  1, 2'b10, 2'b01);
    add(1, 2'b10, 10, 2'b10, 2'b00);
    add(1, 2'b11,  5, 2'b10, 2'b00);
    add(1, 2'b11,  1, 2'b11, 2'b01);
    add(1, 2'b11,  5, 2'b11, 2'b00);
    // simultaneous press and release
    add(1, 2'b00,  5, 2'b11, 2'b00);
    add(1, 2'b00,  1, 2'b00, 2'b11);
    add(1, 2'b00, 14, 2'b00, 2'b00);
    add(1, 2'b11,  5, 2'b00, 2'b00);
    add(1, 2'b11,  1, 2'b11, 2'b11);
    add(1, 2'b11,  5, 2'b11, 2'b00);
    // reset lands mid-debounce; press restarts from scratch
    add(1, 2'b10,  3, 2'b11, 2'b00);
    add(0, 2'b10,  1, 2'b11, 2'b00);
    add(1, 2'b10,  5, 2'b11, 2'b00);
    add(1, 2'b10,  1, 2'b10, 2'b01);
    add(1, 2'b10,  5, 2'b10, 2'b00);
    add(1, 2'b11,  5, 2'b10, 2'b00);
    add(1, 2'b11,  1, 2'b11, 2'b01);
    add(1, 2'b11,  3, 2'b11, 2'b00);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        tick(tbl[r].rstn, tbl[r].raw);
        chk($sformatf("tbl%0d_buttons", r), buttons, tbl[r].eb);
        chk($sformatf("tbl%0d_events", r), button_events, tbl[r].ee);
      end
    end

    // latency of a clean press on bit 1, bounded wait
    cyc = 0;
    do begin
      tick(1, 2'b01);
      cyc++;
    end while (button_events == '0 && cyc <= 20);
    chk("lat_cycles", N'(cyc), N'(SYN + DEB));
    total++;
    if (cyc != SYN + DEB) begin
      bad++;
      $display("FAIL lat_edges: got %0d expected %0d", cyc, SYN + DEB);
    end
    chk("lat_events", button_events, 2'b10);
    chk("lat_buttons", buttons, 2'b01);
    tick(1, 2'b01);
    chk("lat_event_width", button_events, 2'b00);
    for (int k = 0; k < 10; k++) tick(1, 2'b11);
    chk("lat_release_buttons", buttons, 2'b11);

    // randomized bounce traffic against the model
    for (int c = 0; c < N; c++) hold[c] = 0;
    rraw = '1;
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          rraw[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 8);
        end
        hold[c]--;
      end
      rrst = ($urandom_range(0, 299) != 0);
      tick(rrst, rraw);
      chk("rnd_buttons", buttons, m_level);
      chk("rnd_events", button_events, m_event);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
